// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream and writes it into instruction memory.
// Frame layout: header N, then N groups of {opcode, A, B}, then a checksum byte.
// Each group of three bytes is packed into one 20-bit word and written to
// BASE_ADDR + word index. The fetch stage is stalled for the whole load. The
// checksum is the 8-bit sum of the payload bytes.
module imem_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [7:0]  imem_addr,
    output logic [19:0] imem_wdata,
    output logic        stall_out,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  word_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_B0,
        S_B1,
        S_B2,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  n_q, n_d;          // instruction count from the header
    logic [7:0]  idx_q, idx_d;      // index of the word being assembled
    logic [7:0]  sum_q, sum_d;      // running payload checksum
    logic [3:0]  opc_q, opc_d;
    logic [7:0]  a_q, a_d;
    logic [19:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        xfer;

    // The checksum wraps modulo 256.
    function automatic logic [7:0] csum_add(input logic [7:0] s, input logic [7:0] b);
        return s + b;
    endfunction

    function automatic logic [19:0] pack_word(input logic [3:0] opc,
                                              input logic [7:0] a,
                                              input logic [7:0] b);
        return {opc, a, b};
    endfunction

    // Outputs are decoded from the state register only.
    always_comb begin
        byte_ready = (state_q == S_HDR) || (state_q == S_B0) || (state_q == S_B1) ||
                     (state_q == S_B2)  || (state_q == S_CSUM);
        imem_we    = (state_q == S_WRITE);
        busy       = (state_q != S_IDLE);
        stall_out  = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
    end

    assign xfer       = byte_valid && byte_ready;
    assign imem_addr  = BASE_ADDR + idx_q;
    assign imem_wdata = wdata_q;
    assign err        = err_q;
    assign word_count = idx_q;

    // Next-state logic: parse the frame, assemble words and check the checksum.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        opc_d   = opc_q;
        a_d     = a_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HDR;
                    idx_d   = 8'd0;
                    err_d   = 1'b0;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    n_d     = byte_data;
                    sum_d   = 8'd0;
                    state_d = (byte_data == 8'd0) ? S_CSUM : S_B0;
                end
            end
            S_B0: begin
                if (xfer) begin
                    // The opcode is only four bits wide; a set upper nibble means the frame is corrupt.
                    if (byte_data[7:4] != 4'h0) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        opc_d   = byte_data[3:0];
                        sum_d   = csum_add(sum_q, byte_data);
                        state_d = S_B1;
                    end
                end
            end
            S_B1: begin
                if (xfer) begin
                    a_d     = byte_data;
                    sum_d   = csum_add(sum_q, byte_data);
                    state_d = S_B2;
                end
            end
            S_B2: begin
                if (xfer) begin
                    wdata_d = pack_word(opc_q, a_q, byte_data);
                    sum_d   = csum_add(sum_q, byte_data);
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // idx_q < n_q here, so idx_q + 1 cannot wrap.
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q + 8'd1 == n_q) ? S_CSUM : S_B0;
            end
            S_CSUM: begin
                if (xfer) begin
                    if (byte_data == sum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= 8'd0;
            idx_q   <= 8'd0;
            sum_q   <= 8'd0;
            opc_q   <= 4'd0;
            a_q     <= 8'd0;
            wdata_q <= 20'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            opc_q   <= opc_d;
            a_q     <= a_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the pipeline's instruction memory: the writer at the far end of the instruction-fetch path. It accepts a framed byte stream over a valid/ready handshake, packs every three payload bytes into one 20-bit instruction word {opcode[3:0], A[7:0], B[7:0]}, and writes the words to consecutive instruction-memory addresses. While a load is in progress it holds the fetch stage stalled. It verifies a trailing checksum and reports done or error.

## Interface
- BASE_ADDR, 8'h00, first instruction-memory address written; later addresses increment modulo 256.
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a load; ignored unless state is IDLE
- byte_valid  in  1  byte_data holds a valid byte
- byte_data  in  8  stream byte
- byte_ready  out  1  loader can accept a byte this cycle
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  8  write address
- imem_wdata  out  20  instruction word, [19:16] opcode, [15:8] A, [7:0] B
- stall_out  out  1  fetch-stage stall; high while busy
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful load
- err  out  1  sticky error flag
- word_count  out  8  number of words written in the current or last load

## Operation
- Frame format: header byte N = instruction count (0–255), then N groups of 3 bytes (byte0 = {4'h0, opcode}, byte1 = A, byte2 = B), then 1 checksum byte.
- Checksum: 8-bit sum modulo 256 of all bytes after the header, excluding the checksum byte. For N=0 the expected checksum is 8'h00.
- Byte transfer: a byte is transferred in any cycle where byte_valid and byte_ready are both high. byte_ready is combinational from state and is high only in HDR, B0, B1, B2 and CSUM.
- States:
  - IDLE –start→ HDR.
  - HDR –byte→ B0 if N≠0, else CSUM. Latch N and clear the running sum.
  - B0 –byte→ B1. If byte[7:4]≠0, go to ERR instead and write nothing for this word.
  - B1 –byte→ B2.
  - B2 –byte→ WRITE.
  - WRITE, one cycle: imem_we=1. Then go to CSUM if this was word N, else B0.
  - CSUM –byte→ DONE if the byte equals the running sum, else ERR.
  - DONE, one cycle: done=1. Then go to IDLE.
  - ERR → IDLE after one cycle; err stays set.
- Addressing: the word index starts at 0. imem_addr = BASE_ADDR + index, 8-bit, wrapping 8'hFF→8'h00. word_count increments on each WRITE.
- Errors: err clears on an accepted start or on rst. Words already written before an error remain in memory; nothing is rolled back.
- start while busy has no effect. byte_valid while byte_ready is low is ignored and the byte is not consumed.

## Timing
- Reset values: state IDLE; byte_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, stall_out=0, busy=0, done=0, err=0, word_count=0, running sum=0.
- start in cycle t → busy, stall_out and byte_ready high in cycle t+1.
- The third byte of a word is accepted in cycle t → imem_we high in cycle t+1, with imem_addr and imem_wdata stable in that same cycle.
- Peak throughput is 4 cycles per word: 3 byte cycles plus 1 WRITE cycle.
- Checksum byte accepted in cycle t → done=1 in t+1 → busy=0 and stall_out=0 in t+2.
- Checksum mismatch accepted in cycle t → err=1 from t+1 onward; busy falls in t+2.
- rst asserted mid-load → all outputs at their reset values on the next edge. No partial write occurs after that edge.
- imem_we is never high in the same cycle as byte_ready.

## Test plan
- BASE_ADDR=0; start, then bytes 02, 01,05,03, 02,10,01, 1C → writes 0x10503 @0x00 and 0x21001 @0x01; done pulse; word_count=2; err=0.
- Header 00 followed by checksum 00 → no imem_we; done pulse; word_count=0. The same frame with checksum 07 → err=1 and no done.
- N=1, byte0=0x31 → err=1 immediately, no imem_we, byte_ready low from the next cycle; the subsequent start clears err.
- BASE_ADDR=8'hFE, N=3 with a valid frame → writes at 0xFE, 0xFF, 0x00; done pulse.
- byte_valid toggled randomly 50% over the first frame → identical writes and done; stall_out high for the whole load; a start issued mid-load is ignored.
- rst asserted during B1 of word 2 → outputs reset the next cycle; word 1 was written, word 2 never written; a fresh load then completes normally.
